// File: rtl/flow_rd_sched.sv
// flow_rd_sched: read scheduler for the per-flow packet-size accumulator.
// Arbitrates between a host requester (req/ack) and a background sweep over
// all flow indices, issues one read/clear strobe at a time, captures the
// returned count RD_LAT cycles later and offers it on a valid/ready port.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   host_req_i/flow_i      host read request (level) and flow index
//   host_ack_o             one-cycle pulse, host request accepted
//   sweep_en_i             enable background sweep
//   sweep_wrap_o           pulse when the sweep index wraps to 0
//   rd_stb_o/flow_num_o    read/clear strobe and flow to accumulator
//   rd_data_i/data_val_i   accumulator read data and valid
//   res_valid_o/ready_i    result handshake
//   res_flow_o/data_o      flow index and captured count
//   res_src_o              0 = host, 1 = sweep
//   res_err_o              read data was not valid at capture
module flow_rd_sched #(
    parameter int unsigned A_WIDTH = 10,
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned RD_LAT  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               host_req_i,
    input  logic [A_WIDTH-1:0] host_flow_i,
    output logic               host_ack_o,
    input  logic               sweep_en_i,
    output logic               sweep_wrap_o,
    output logic               rd_stb_o,
    output logic [A_WIDTH-1:0] rd_flow_num_o,
    input  logic [D_WIDTH-1:0] rd_data_i,
    input  logic               rd_data_val_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [A_WIDTH-1:0] res_flow_o,
    output logic [D_WIDTH-1:0] res_data_o,
    output logic               res_src_o,
    output logic               res_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t             state_q, state_d;
    // grant_q marks the IDLE cycle in which a grant is being presented
    // (host_ack_o high); the strobe follows in the next cycle.
    logic               grant_q, grant_d;
    logic [A_WIDTH-1:0] flow_q, flow_d;
    logic               src_q, src_d;
    logic               last_q, last_d;
    logic [A_WIDTH-1:0] idx_q, idx_d;
    logic [3:0]         cnt_q, cnt_d;

    logic               ack_q, ack_d;
    logic               wrap_q, wrap_d;
    logic               stb_q, stb_d;
    logic [A_WIDTH-1:0] rdflow_q, rdflow_d;
    logic               valid_q, valid_d;
    logic [A_WIDTH-1:0] rflow_q, rflow_d;
    logic [D_WIDTH-1:0] rdata_q, rdata_d;
    logic               rsrc_q, rsrc_d;
    logic               rerr_q, rerr_d;

    logic               arb_en;
    logic               host_win;
    logic               sweep_win;
    logic [A_WIDTH-1:0] idx_inc;

    assign idx_inc   = idx_q + {{(A_WIDTH-1){1'b0}}, 1'b1};
    // On a tie the host wins only if the sweep had the previous grant.
    assign host_win  = host_req_i & (~sweep_en_i | last_q);
    assign sweep_win = sweep_en_i & ~host_win;

    always_comb begin
        state_d  = state_q;
        grant_d  = 1'b0;
        flow_d   = flow_q;
        src_d    = src_q;
        last_d   = last_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        wrap_d   = 1'b0;
        stb_d    = 1'b0;
        rdflow_d = rdflow_q;
        valid_d  = 1'b0;
        rflow_d  = rflow_q;
        rdata_d  = rdata_q;
        rsrc_d   = rsrc_q;
        rerr_d   = rerr_q;
        arb_en   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_q) begin
                    state_d  = S_ISSUE;
                    stb_d    = 1'b1;
                    rdflow_d = flow_q;
                    if (src_q) begin
                        idx_d  = idx_inc;
                        wrap_d = (idx_inc == '0);
                    end
                end else begin
                    arb_en = 1'b1;
                end
            end
            S_ISSUE: begin
                cnt_d   = 4'(RD_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                    valid_d = 1'b1;
                    rflow_d = flow_q;
                    rsrc_d  = src_q;
                    rerr_d  = ~rd_data_val_i;
                    rdata_d = rd_data_val_i ? rd_data_i : '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                valid_d = 1'b1;
                if (res_ready_i) begin
                    // Arbitration here makes the grant visible in the
                    // following IDLE cycle, never in the handshake cycle.
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                    arb_en  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (arb_en && (host_win || sweep_win)) begin
            grant_d = 1'b1;
            flow_d  = host_win ? host_flow_i : idx_q;
            src_d   = ~host_win;
            last_d  = ~host_win;
            ack_d   = host_win;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            grant_q  <= 1'b0;
            flow_q   <= '0;
            src_q    <= 1'b0;
            last_q   <= 1'b1;
            idx_q    <= '0;
            cnt_q    <= 4'd0;
            ack_q    <= 1'b0;
            wrap_q   <= 1'b0;
            stb_q    <= 1'b0;
            rdflow_q <= '0;
            valid_q  <= 1'b0;
            rflow_q  <= '0;
            rdata_q  <= '0;
            rsrc_q   <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            flow_q   <= flow_d;
            src_q    <= src_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            wrap_q   <= wrap_d;
            stb_q    <= stb_d;
            rdflow_q <= rdflow_d;
            valid_q  <= valid_d;
            rflow_q  <= rflow_d;
            rdata_q  <= rdata_d;
            rsrc_q   <= rsrc_d;
            rerr_q   <= rerr_d;
        end
    end

    assign host_ack_o    = ack_q;
    assign sweep_wrap_o  = wrap_q;
    assign rd_stb_o      = stb_q;
    assign rd_flow_num_o = rdflow_q;
    assign res_valid_o   = valid_q;
    assign res_flow_o    = rflow_q;
    assign res_data_o    = rdata_q;
    assign res_src_o     = rsrc_q;
    assign res_err_o     = rerr_q;

endmodule
